// File: rtl/booth_pp_accumulator.sv
// Serial radix-4 Booth back end: accumulates one recoded digit per cycle.
// Optional BOOTH_DIGIT_CHECK_EN flags illegal one=zero=1 digits on err.
module booth_pp_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic               dig_valid,
  input  logic               one,
  input  logic               neg,
  input  logic               zero,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               err
);

  localparam int DIGITS = WIDTH / 2 + 1;
  localparam int AW     = 2 * WIDTH + 3;
  localparam int CW     = $clog2(DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]     xr;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] xe;
  logic signed [AW-1:0] mag;
  logic signed [AW-1:0] term;
  logic signed [AW-1:0] sum;
  logic [CW-1:0]        cnt;
  logic                 accept;
  logic                 take;
  logic                 last;

  assign accept = start && (state_q != RUN);
  assign take   = dig_valid && (state_q == RUN);
  assign last   = (cnt == CW'(DIGITS - 1));

  // Partial product d*xr placed at weight 4^cnt
  always_comb begin
    xe   = AW'(xr);
    mag  = one ? xe : (xe <<< 1);
    term = '0;
    if (!zero) term = neg ? -mag : mag;
    sum  = acc + (term <<< {cnt, 1'b0});
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (take && last) state_d = DONE;
      DONE: state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr      <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      xr  <= x;
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
      if (last) product <= sum[2*WIDTH-1:0];
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

`ifdef BOOTH_DIGIT_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       err_q <= 1'b0;
    else if (accept)               err_q <= 1'b0;
    else if (take && one && zero)  err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Randomized bench for booth_pp_accumulator against an arithmetic
// model: product = sum of Booth digits * x * 4^i.
module tb_booth_pp_accumulator;

  localparam int W  = 8;
  localparam int ND = W / 2 + 1;
  localparam bit CHK =
`ifdef BOOTH_DIGIT_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   x;
  logic           dig_valid;
  logic           one;
  logic           neg;
  logic           zero;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           err;

  int n_chk;
  int n_fail;

  booth_pp_accumulator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x         (x),
    .dig_valid (dig_valid),
    .one       (one),
    .neg       (neg),
    .zero      (zero),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bit_at(input logic [W-1:0] m,
                                input int j);
    if (j < 0 || j >= W) return 0;
    return m[j] ? 1 : 0;
  endfunction

  function automatic int bdig(input logic [W-1:0] m,
                              input int i);
    return -2 * bit_at(m, 2*i+1) + bit_at(m, 2*i)
           + bit_at(m, 2*i-1);
  endfunction

  // Full product run; returns in the DONE cycle.
  task automatic run(input logic [W-1:0] xv,
                     input logic [W-1:0] mv,
                     input bit stall,
                     input int bad,
                     input bit zneg1,
                     input bit poke,
                     input string tag);
    int     d[ND];
    longint ep;
    int     cyc;
    int     i;
    bit     v;
    bit     err_e;
    ep = 0;
    for (int k = 0; k < ND; k++) begin
      d[k] = bdig(mv, k);
      if (k != bad)
        ep += longint'(d[k]) * longint'(xv)
              * (longint'(1) << (2 * k));
    end
    x = xv;
    start = 1'b1;
    tick();
    start = 1'b0;
    x = ~xv;
    chk({tag, ".busy0"}, 64'(busy), 64'd1);
    chk({tag, ".errclr"}, 64'(err), 64'd0);
    err_e = 1'b0;
    cyc = 0;
    i = 0;
    while (i < ND && cyc < 4 * ND) begin
      v = stall ? (cyc % 2 == 0) : 1'b1;
      dig_valid = v;
      one  = 1'($urandom_range(0, 1));
      neg  = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      if (v) begin
        zero = (d[i] == 0);
        one  = (d[i] == 1 || d[i] == -1);
        neg  = (d[i] < 0) || (d[i] == 0 &&
               (zneg1 || $urandom_range(0, 1) == 1));
        if (i == bad) begin
          one  = 1'b1;
          zero = 1'b1;
        end
      end
      start = poke && (cyc == 1);
      x = W'($urandom);
      tick();
      start = 1'b0;
      if (v) begin
        if (i == bad) err_e = CHK;
        i++;
      end
      cyc++;
      chk({tag, ".err"}, 64'(err), 64'(err_e));
      if (i < ND) begin
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        chk({tag, ".nodone"}, 64'(done), 64'd0);
      end
    end
    dig_valid = 1'b0;
    chk({tag, ".cycles"}, 64'(cyc),
        64'(stall ? 2 * ND - 1 : ND));
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".busyoff"}, 64'(busy), 64'd0);
    chk({tag, ".product"}, 64'(product), 64'(ep));
  endtask

  task automatic idle_after(input logic [2*W-1:0] p,
                            input string tag);
    tick();
    chk({tag, ".pulse"}, 64'(done), 64'd0);
    chk({tag, ".idle"}, 64'(busy), 64'd0);
    chk({tag, ".hold"}, 64'(product), 64'(p));
  endtask

  initial begin
    logic [W-1:0]   xa;
    logic [W-1:0]   ma;
    logic [2*W-1:0] p;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    x = '0;
    dig_valid = 1'b0;
    one = 1'b0;
    neg = 1'b0;
    zero = 1'b0;
    tick();
    tick();
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.product", 64'(product), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    rst = 1'b0;
    tick();

    run(8'hFF, 8'hFF, 1'b0, -1, 1'b1, 1'b0, "ff");
    chk("ff.const", 64'(product), 64'h0000FE01);
    idle_after(16'hFE01, "ff");
    run(8'h00, W'($urandom), 1'b0, -1, 1'b0, 1'b0, "x0");
    idle_after(16'h0000, "x0");
    run(W'($urandom), 8'h00, 1'b0, -1, 1'b0, 1'b0, "m0");
    idle_after(16'h0000, "m0");
    run(8'h80, 8'h02, 1'b0, -1, 1'b0, 1'b0, "x80");
    chk("x80.const", 64'(product), 64'h00000100);
    idle_after(16'h0100, "x80");
    run(8'h0D, 8'h0B, 1'b1, -1, 1'b0, 1'b0, "stall");
    chk("stall.const", 64'(product), 64'h0000008F);
    idle_after(16'h008F, "stall");

    run(8'h37, 8'h5A, 1'b0, -1, 1'b0, 1'b1, "poke");
    p = 16'(8'h37 * 8'h5A);
    idle_after(p, "poke");
    dig_valid = 1'b1;
    one = 1'b1;
    tick();
    dig_valid = 1'b0;
    chk("ivalid.busy", 64'(busy), 64'd0);
    chk("ivalid.done", 64'(done), 64'd0);
    chk("ivalid.product", 64'(product), 64'(p));

    xa = W'($urandom);
    run(xa, 8'h05, 1'b0, 2, 1'b0, 1'b0, "bad");
    run(8'hC3, 8'hA7, 1'b0, -1, 1'b0, 1'b0, "b2b");
    p = 16'(8'hC3 * 8'hA7);
    idle_after(p, "b2b");

    x = 8'h99;
    start = 1'b1;
    tick();
    start = 1'b0;
    dig_valid = 1'b1;
    one = 1'b1;
    neg = 1'b0;
    zero = 1'b0;
    tick();
    tick();
    dig_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk("midrst.product", 64'(product), 64'd0);
    chk("midrst.err", 64'(err), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("postrst.busy", 64'(busy), 64'd0);
    chk("postrst.product", 64'(product), 64'd0);
    run(8'hB5, 8'h6E, 1'b0, -1, 1'b0, 1'b0, "fresh");
    idle_after(16'(8'hB5 * 8'h6E), "fresh");

    for (int r = 0; r < 25; r++) begin
      xa = W'($urandom);
      ma = W'($urandom);
      run(xa, ma, 1'($urandom_range(0, 1)), -1,
          1'b0, 1'($urandom_range(0, 1)), "rnd");
      if ($urandom_range(0, 1) == 1)
        idle_after(16'(xa * ma), "rnd");
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
